uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 21 ++
 rtl/uart_tx_rr_pick.sv | 31 +++
 rtl/uart_tx_sched.sv | 117 +++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART transmitter definitions: scheduler state encoding, default widths
// and an index-width helper used by the transmitter blocks.
package uart_tx_sched_pkg;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_TO_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin pick: first set request after ptr_i (wrapping), zero latency.
// No backpressure of its own; any_o flags whether win_o is meaningful.
module uart_tx_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    cand  = '0;
    // Offset NREQ wraps back to ptr_i itself, so the last winner is considered last.
    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(ptr_i) + off) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        win_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter: launch one cycle after the grant decision,
// then holds the byte until the UART finishes or fails to go busy; tx_busy in IDLE blocks all grants.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ack,
  input  logic                     tx_busy,
  output logic                     tx_data_valid,
  output logic [DW-1:0]            tx_p_data,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     active,
  output logic                     err_timeout
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(TO_CYCLES + 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [DW-1:0] data_q, data_d;

  logic [IW-1:0]   win;
  logic            any_req;
  logic            launch;
  logic            timeout;
  logic [NREQ-1:0] ack;

  uart_tx_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (last_q),
    .win_o (win),
    .any_o (any_req)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    launch  = 1'b0;
    timeout = 1'b0;
    ack     = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_req && !tx_busy) begin
          grant_d = win;
          data_d  = req_data[int'(win)*DW +: DW];
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        launch       = 1'b1;
        ack[grant_q] = 1'b1;
        cnt_d        = '0;
        state_d      = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(TO_CYCLES)) begin
          // A UART that never answers still advances the round-robin pointer.
          timeout = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_data_valid = launch;
  assign req_ack       = ack;
  assign err_timeout   = timeout;
  assign active        = (state_q != ST_IDLE);
  assign grant_id      = grant_q;
  assign tx_p_data     = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench: rounds of requests are turned into an expected launch order by a
// plain round-robin model; a monitor pops and compares on every launch and every cycle.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 4;
  localparam int IW   = 2;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              tx_busy;
  logic              tx_data_valid;
  logic [DW-1:0]     tx_p_data;
  logic [IW-1:0]     grant_id;
  logic              active;
  logic              err_timeout;

  logic uart_busy;
  logic force_busy;
  assign tx_busy = uart_busy | force_busy;

  typedef struct {int id; logic [DW-1:0] data; bit dead;} exp_t;
  typedef struct {bit dead; int dly; int len;} mode_t;

  exp_t  exp_q[$];
  mode_t mode_q[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int model_last = NREQ - 1;
  int dly_left   = 0;
  int len_left   = 0;
  int blen       = 0;

  int            cur_id;
  logic [DW-1:0] cur_data;
  bit            have_cur;
  bit            cur_dead;
  int            launch_cyc;

  uart_tx_sched #(
    .NREQ      (NREQ),
    .DW        (DW),
    .TO_CYCLES (TO)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .grant_id      (grant_id),
    .active        (active),
    .err_timeout   (err_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // UART model: busy rises dly cycles after the strobe and lasts len cycles; dead frames never go busy.
  initial begin
    mode_t m;
    uart_busy = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (!RST) begin
        uart_busy = 1'b0;
        dly_left  = 0;
        len_left  = 0;
      end else begin
        if (dly_left > 0) begin
          dly_left--;
          if (dly_left == 0) begin
            uart_busy = 1'b1;
            len_left  = blen;
          end
        end else if (len_left > 0) begin
          len_left--;
          if (len_left == 0) uart_busy = 1'b0;
        end
        if (tx_data_valid && mode_q.size() > 0) begin
          m = mode_q.pop_front();
          if (!m.dead) begin
            dly_left = m.dly;
            blen     = m.len;
          end
        end
      end
    end
  end

  // Monitor: compares every launch against the scoreboard and checks hold/timeout behaviour each cycle.
  initial begin
    exp_t e;
    cur_id = 0; cur_data = '0; have_cur = 0; cur_dead = 0; launch_cyc = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        cur_id   = 0;
        cur_data = '0;
        have_cur = 0;
      end else begin
        if (tx_data_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_launch: grant %0d byte 0x%0h with empty scoreboard (cycle %0d)",
                     grant_id, tx_p_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("launch_grant_id", 32'(grant_id), e.id);
            check("launch_byte", 32'(tx_p_data), 32'(e.data));
            check("launch_ack", 32'(req_ack), 1 << e.id);
            check("launch_active", 32'(active), 1);
            cur_id     = e.id;
            cur_data   = e.data;
            cur_dead   = e.dead;
            have_cur   = 1;
            launch_cyc = cyc;
          end
        end else begin
          check("ack_outside_launch", 32'(req_ack), 0);
          check("byte_hold", 32'(tx_p_data), 32'(cur_data));
          check("grant_hold", 32'(grant_id), cur_id);
        end
        check("err_timeout", 32'(err_timeout),
              32'(have_cur && cur_dead && (cyc == launch_cyc + 1 + TO)));
        if (have_cur && cur_dead && (cyc == launch_cyc + 2 + TO))
          check("timeout_back_to_idle", 32'(active), 0);
      end
    end
  end

  task automatic run_round(input logic [NREQ-1:0] set, input logic [NREQ-1:0] dead_mask,
                           input logic [NREQ*DW-1:0] bytes, input int block,
                           input int fixed_len, input bit abort);
    logic [NREQ-1:0] pending, acked;
    int    id, budget, assert_cyc;
    bit    found, chk_lat, first;
    exp_t  e;
    mode_t m;
    pending = set;
    id = 0;
    while (pending != '0) begin
      found = 0;
      for (int off = 1; off <= NREQ; off++) begin
        if (!found && pending[IW'((model_last + off) % NREQ)]) begin
          id    = (model_last + off) % NREQ;
          found = 1;
        end
      end
      pending[IW'(id)] = 1'b0;
      model_last = id;
      e.id   = id;
      e.data = bytes[id*DW +: DW];
      e.dead = dead_mask[IW'(id)];
      m.dead = dead_mask[IW'(id)];
      m.dly  = (fixed_len > 0) ? 1 : int'($urandom_range(1, TO + 1));
      m.len  = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 14));
      exp_q.push_back(e);
      mode_q.push_back(m);
    end

    for (int i = 0; i < NREQ; i++)
      if (set[IW'(i)]) req_data[i*DW +: DW] = bytes[i*DW +: DW];
    force_busy = (block > 0);
    chk_lat    = (block == 0) && !active && !tx_busy;
    req_valid  = req_valid | set;
    assert_cyc = cyc;
    for (int k = 0; k < block; k++) begin
      @(posedge CLK); #1;
      check("blocked_launch", 32'(tx_data_valid), 0);
      check("blocked_ack", 32'(req_ack), 0);
    end
    force_busy = 1'b0;

    acked  = '0;
    first  = 1;
    budget = 0;
    while (acked != set && budget < 400) begin
      @(posedge CLK); #1;
      budget++;
      if ((req_ack & set) != '0) begin
        if (first && chk_lat) check("launch_latency", cyc - assert_cyc, 1);
        first = 0;
        acked = acked | req_ack;
        // Drop the request and scramble its byte in the launch cycle: the captured byte must survive.
        for (int i = 0; i < NREQ; i++) begin
          if (req_ack[IW'(i)]) begin
            req_valid[IW'(i)]    = 1'b0;
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end
      end
    end
    check("round_acks", 32'(acked), 32'(set));

    if (abort) begin
      budget = 0;
      while (!uart_busy && budget < 50) begin
        @(posedge CLK); #1;
        budget++;
      end
      repeat (2) begin
        @(posedge CLK); #1;
      end
      check("abort_midframe_active", 32'(active), 1);
      RST = 1'b0;
      #1;
      check("abort_tx_data_valid", 32'(tx_data_valid), 0);
      check("abort_req_ack", 32'(req_ack), 0);
      check("abort_active", 32'(active), 0);
      check("abort_err_timeout", 32'(err_timeout), 0);
      check("abort_grant_id", 32'(grant_id), 0);
      check("abort_tx_p_data", 32'(tx_p_data), 0);
      model_last = NREQ - 1;
      req_valid  = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
    end else begin
      budget = 0;
      while (active && budget < 300) begin
        @(posedge CLK); #1;
        budget++;
      end
      check("round_returns_idle", 32'(active), 0);
    end
  endtask

  initial begin
    logic [NREQ-1:0] rset, rdead;
    int              rblock;
    RST        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    force_busy = 1'b0;
    #3 RST = 1'b0;
    #1;
    check("reset_tx_data_valid", 32'(tx_data_valid), 0);
    check("reset_req_ack", 32'(req_ack), 0);
    check("reset_active", 32'(active), 0);
    check("reset_err_timeout", 32'(err_timeout), 0);
    check("reset_grant_id", 32'(grant_id), 0);
    check("reset_tx_p_data", 32'(tx_p_data), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;

    // All four at once with a 12-cycle UART, then requester 0 alone: order 0,1,2,3,0.
    run_round(4'b1111, 4'b0000, 32'h44332211, 0, 12, 0);
    run_round(4'b0001, 4'b0000, 32'h000000A5, 0, 12, 0);
    // Requester 1 drops and scrambles its byte during launch.
    run_round(4'b0010, 4'b0000, 32'($urandom), 0, 0, 0);
    // Dead UART on requester 1, then requester 2 must win over 1.
    run_round(4'b0010, 4'b0010, 32'($urandom), 0, 0, 0);
    run_round(4'b0110, 4'b0000, 32'($urandom), 0, 0, 0);
    // tx_busy high in IDLE blocks all four.
    run_round(4'b1111, 4'b0000, 32'($urandom), 8, 0, 0);
    // Reset mid-frame, then 3 alone, then 0 wins over 3.
    run_round(4'b0100, 4'b0000, 32'h005C0000, 0, 12, 1);
    run_round(4'b1000, 4'b0000, 32'($urandom), 0, 0, 0);
    run_round(4'b1001, 4'b0000, 32'($urandom), 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      rset   = 4'($urandom_range(1, 15));
      rdead  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      rblock = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_round(rset, rdead, 32'($urandom), rblock, 0, 0);
    end

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
